mc_seq: RTL and testbench

Multicycle sequencer for the processor datapath: a Moore/Mealy FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the PC, IR, MDR, register-file and memory-port enables so that one unified memory port and one ALU serve the whole instruction. It sits beside the combinational control unit `cu`, which keeps generating ALU ops and immediates, and replaces single-cycle write-enable timing.

---
 rtl/cu_pkg.sv | 44 ++++
 rtl/op_class_dec.sv | 28 ++
 rtl/mc_seq.sv | 129 ++++++++++++
 tb/tb_mc_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control unit and the multicycle sequencer:
// states, RV32I major opcodes, instruction classes and mux selects.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC
    } op_class_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MDR   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

endpackage

// File: rtl/op_class_dec.sv
// Combinational opcode-to-class mapping with an illegal flag for anything
// outside the supported RV32I major opcodes.
module op_class_dec
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CL_R;
        illegal  = 1'b0;
        case (opcode)
            OP_R:      op_class = CL_R;
            OP_I:      op_class = CL_I;
            OP_LOAD:   op_class = CL_LOAD;
            OP_STORE:  op_class = CL_STORE;
            OP_BRANCH: op_class = CL_BRANCH;
            OP_JAL:    op_class = CL_JAL;
            OP_JALR:   op_class = CL_JALR;
            OP_LUI:    op_class = CL_LUI;
            OP_AUIPC:  op_class = CL_AUIPC;
            default:   illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_seq.sv
// Multicycle sequencer: steps each instruction through FETCH, DECODE, EXEC,
// MEM and WB, sharing one memory port and one ALU across the instruction.
module mc_seq
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    state_t    state_q, state_d;
    op_class_t class_q, dec_class;
    logic      illegal_q, dec_illegal;

    op_class_dec u_dec (
        .opcode   (opcode),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_R;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                class_q <= dec_class;
                if (dec_illegal)
                    illegal_q <= 1'b1;
            end
        end
    end

    // Output decode is gated by reset so an in-flight access is dropped at once.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        instr_done = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = dec_illegal ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    case (class_q)
                        CL_LOAD, CL_STORE: state_d = ST_MEM;
                        CL_BRANCH: begin
                            pc_we      = 1'b1;
                            pc_src     = br_taken ? PC_IMM : PC_PLUS4;
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end
                        default: state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (class_q == CL_STORE);
                    if (mem_ready) begin
                        if (class_q == CL_STORE) begin
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end else begin
                            mdr_we  = 1'b1;
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                    case (class_q)
                        CL_LOAD: wb_sel = WB_MDR;
                        CL_JAL: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_IMM;
                        end
                        CL_JALR: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_ALU;
                        end
                        default: wb_sel = WB_ALU;
                    endcase
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_seq.sv
// Self-checking bench for mc_seq: a directed vector table, randomized
// instruction traces from a per-instruction reference model, and reset corners.
module tb_mc_seq;
    import cu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0] pc_src, wb_sel;
    logic       reg_we, instr_done, illegal;
    logic [2:0] state;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       illegal;
        logic [2:0] state;
    } obs_t;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic       br;
        logic       rdy;
        obs_t       exp;
    } vec_t;

    int    vectors = 0;
    int    miscompares = 0;
    string test_name = "init";
    vec_t  sched[$];
    vec_t  tbl[7];
    logic [6:0] legal_ops[9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    mc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .br_taken   (br_taken),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .mdr_we     (mdr_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(logic [2:0] st, logic mreq, logic mwe, logic asel,
                                logic irw, logic mdrw, logic pcw, logic [1:0] psrc,
                                logic rw, logic [1:0] wsel, logic done, logic ill);
        obs_t o;
        o.state = st; o.mem_req = mreq; o.mem_we = mwe; o.addr_sel = asel;
        o.ir_we = irw; o.mdr_we = mdrw; o.pc_we = pcw; o.pc_src = psrc;
        o.reg_we = rw; o.wb_sel = wsel; o.instr_done = done; o.illegal = ill;
        return o;
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function void push(logic rst_n, logic [6:0] op, logic br, logic rdy, obs_t e);
        vec_t v;
        v.rst_n = rst_n; v.op = op; v.br = br; v.rdy = rdy; v.exp = e;
        sched.push_back(v);
    endfunction

    // Reference model: expected per-cycle trace of one instruction, derived
    // from its class, branch outcome and the number of memory wait cycles.
    function void model_instr(logic [6:0] op, logic br, int fetch_waits, int mem_waits);
        logic is_load, is_store, is_branch, is_jal, is_jalr, legal;
        obs_t o;
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_branch = (op == OP_BRANCH);
        is_jal    = (op == OP_JAL);
        is_jalr   = (op == OP_JALR);
        legal     = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                               OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int i = 0; i < fetch_waits; i++)
            push(1'b1, rnd_op(), rnd_bit(), 1'b0,
                 ob(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        push(1'b1, rnd_op(), rnd_bit(), 1'b1,
             ob(3'd0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        push(1'b1, op, rnd_bit(), rnd_bit(),
             ob(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        if (!legal)
            return;
        if (is_branch) begin
            push(1'b1, rnd_op(), br, rnd_bit(),
                 ob(3'd2, 0, 0, 0, 0, 0, 1, br ? 2'b01 : 2'b00, 0, 2'b00, 1, 0));
            return;
        end
        push(1'b1, rnd_op(), rnd_bit(), rnd_bit(),
             ob(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        if (is_load || is_store) begin
            for (int i = 0; i < mem_waits; i++)
                push(1'b1, rnd_op(), rnd_bit(), 1'b0,
                     ob(3'd3, 1, is_store, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
            push(1'b1, rnd_op(), rnd_bit(), 1'b1,
                 ob(3'd3, 1, is_store, 1, 0, is_load, is_store, 2'b00, 0, 2'b00, is_store, 0));
            if (is_store)
                return;
        end
        push(1'b1, rnd_op(), rnd_bit(), rnd_bit(),
             ob(3'd4, 0, 0, 0, 0, 0, 1,
                is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00), 1,
                is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00), 1, 0));
    endfunction

    task automatic checkOutput(input obs_t exp);
        obs_t act;
        act = ob(state, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src,
                 reg_we, wb_sel, instr_done, illegal);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s vec%0d: got %h (state %0d) expected %h (state %0d)",
                     test_name, vectors, act, act.state, exp, exp.state);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst_n;
        opcode    = v.op;
        br_taken  = v.br;
        mem_ready = v.rdy;
        @(negedge clk);
        checkOutput(v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_sched();
        while (sched.size() > 0)
            applyStimulus(sched.pop_front());
    endtask

    initial begin
        reset = 1'b0; opcode = OP_R; br_taken = 1'b0; mem_ready = 1'b0;

        tbl[0] = '{1'b0, OP_R, 1'b0, 1'b1, ob(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0)};
        tbl[1] = '{1'b0, OP_R, 1'b0, 1'b1, ob(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0)};
        tbl[2] = '{1'b1, OP_R, 1'b0, 1'b1, ob(3'd0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0)};
        tbl[3] = '{1'b1, OP_R, 1'b0, 1'b1, ob(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0)};
        tbl[4] = '{1'b1, OP_R, 1'b0, 1'b1, ob(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0)};
        tbl[5] = '{1'b1, OP_R, 1'b0, 1'b1, ob(3'd4, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0)};
        tbl[6] = '{1'b1, OP_R, 1'b0, 1'b0, ob(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0)};

        @(posedge clk);
        #1;
        test_name = "alu_table";
        for (int i = 0; i < 7; i++)
            applyStimulus(tbl[i]);

        test_name = "load_wait2";
        model_instr(OP_LOAD, 1'b0, 0, 2);
        run_sched();
        test_name = "branch_taken";
        model_instr(OP_BRANCH, 1'b1, 0, 0);
        run_sched();
        test_name = "branch_not_taken";
        model_instr(OP_BRANCH, 1'b0, 0, 0);
        run_sched();
        test_name = "jalr";
        model_instr(OP_JALR, 1'b0, 0, 0);
        run_sched();

        test_name = "random";
        for (int n = 0; n < 60; n++) begin
            model_instr(legal_ops[$urandom_range(0, 8)], rnd_bit(),
                        $urandom_range(0, 2), $urandom_range(0, 2));
            run_sched();
        end

        test_name = "illegal_trap";
        model_instr(7'b1111111, 1'b0, 1, 0);
        for (int i = 0; i < 21; i++)
            push(1'b1, rnd_op(), rnd_bit(), rnd_bit(),
                 ob(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
        push(1'b0, rnd_op(), rnd_bit(), rnd_bit(),
             ob(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        model_instr(OP_I, 1'b0, 0, 0);
        run_sched();

        test_name = "reset_mid_store";
        push(1'b1, rnd_op(), 1'b0, 1'b1, ob(3'd0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        push(1'b1, OP_STORE, 1'b0, 1'b0, ob(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        push(1'b1, rnd_op(), 1'b0, 1'b0, ob(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        push(1'b1, rnd_op(), 1'b0, 1'b0, ob(3'd3, 1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        run_sched();
        mem_ready = 1'b0;
        #2;
        checkOutput(ob(3'd3, 1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        reset = 1'b0;
        #1;
        checkOutput(ob(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        push(1'b0, rnd_op(), 1'b0, 1'b1, ob(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        model_instr(OP_R, 1'b0, 1, 0);
        run_sched();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
